// File: rtl/spi_master_wb_pkg.sv
// Shared definitions for the angle-sensor SPI master: register offsets, CTRL/STATUS layout, FSM states.
package spi_master_wb_pkg;

    localparam logic [1:0] OFFSET_SPI_CTRL   = 2'b00;
    localparam logic [1:0] OFFSET_SPI_DATA   = 2'b01;
    localparam logic [1:0] OFFSET_SPI_STATUS = 2'b10;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_OVR  = 2;

    typedef struct packed {
        logic       ss;
        logic       ie;
        logic       lsb;
        logic       ass;
        logic       tx_neg;
        logic       rx_neg;
        logic [1:0] rsvd;
        logic [2:0] div;
        logic [4:0] len;
    } ctrl_t;

    // Subset of CTRL frozen for the duration of one transfer
    typedef struct packed {
        logic       lsb;
        logic       ass;
        logic       tx_neg;
        logic       rx_neg;
        logic [2:0] div;
        logic [4:0] len;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    function automatic logic [4:0] eff_len(input logic [4:0] len);
        return (len == 5'd0 || len > 5'd16) ? 5'd16 : len;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SPI half-period timer: counts DIV+1 clocks per half period and drives sclk with edge strobes.
module spi_clkgen (
    input  logic       clk64_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       toggle_en_i,
    input  logic [2:0] div_i,
    output logic       tick_c_o,
    output logic       rise_c_o,
    output logic       fall_c_o,
    output logic       sclk_o
);

    logic [2:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;

    assign tick_c_o = en_i && (cnt_q == div_i);
    assign rise_c_o = tick_c_o && toggle_en_i && !sclk_q;
    assign fall_c_o = tick_c_o && toggle_en_i && sclk_q;
    assign sclk_o   = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i || tick_c_o) cnt_d = 3'd0;
        else                   cnt_d = cnt_q + 3'd1;
        // sclk is forced low outside SHIFT so it always parks idle-low
        if (!toggle_en_i)      sclk_d = 1'b0;
        else if (tick_c_o)     sclk_d = ~sclk_q;
    end

    always_ff @(posedge clk64_i) begin
        if (rst_i) begin
            cnt_q  <= 3'd0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_wb.sv
// Register-mapped SPI master for the angle-sensor ADC: CTRL/DATA/STATUS registers, transfer FSM, shifter, irq.
module spi_master_wb
    import spi_master_wb_pkg::*;
#(
    parameter int unsigned    DW       = 16,
    parameter logic [DW-1:0]  CTRL_RST = '0
) (
    input  logic          clk64_i,
    input  logic          rst_i,
    input  logic          cyc_i,
    input  logic          stb_i,
    input  logic          we_i,
    input  logic [1:0]    adr_i,
    input  logic [DW-1:0] dat_i,
    output logic [DW-1:0] dat_o,
    output logic          ack_o,
    output logic          irq_o,
    output logic          sclk_o,
    output logic          mosi_o,
    input  logic          miso_i,
    output logic          ss_n_o
);

    state_t        state_q, state_d;
    ctrl_t         ctrl_q, ctrl_d;
    shadow_t       sh_q, sh_d;
    logic [DW-1:0] tx_q, tx_d, rxs_q, rxs_d, rx_q, rx_d, dat_q, dat_d;
    logic [5:0]    edge_q, edge_d;
    logic          done_q, done_d, ovr_q, ovr_d, ack_q, ack_d, irq_q, irq_d;
    logic          mosi_q, mosi_d, ss_n_q, ss_n_d;

    logic          tick, rise, fall;
    logic          access, wr, rd, done_set, last_edge, tx_edge, rx_edge;
    logic [4:0]    len_cur, len_new;
    logic [DW-1:0] tx_load, status;

    spi_clkgen u_clkgen (
        .clk64_i     (clk64_i),
        .rst_i       (rst_i),
        .en_i        (state_q != ST_IDLE),
        .toggle_en_i (state_q == ST_SHIFT),
        .div_i       (sh_q.div),
        .tick_c_o    (tick),
        .rise_c_o    (rise),
        .fall_c_o    (fall),
        .sclk_o      (sclk_o)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        rxs_d    = rxs_q;
        rx_d     = rx_q;
        dat_d    = dat_q;
        edge_d   = edge_q;
        done_d   = done_q;
        ovr_d    = ovr_q;
        mosi_d   = mosi_q;
        done_set = 1'b0;

        access    = cyc_i & stb_i;
        wr        = access & we_i;
        rd        = access & ~we_i;
        ack_d     = access;
        len_cur   = eff_len(sh_q.len);
        len_new   = eff_len(ctrl_q.len);
        last_edge = (edge_q == ({len_cur, 1'b0} - 6'd1));
        tx_edge   = sh_q.tx_neg ? fall : rise;
        rx_edge   = sh_q.rx_neg ? fall : rise;
        // MSB-first words are pre-aligned so the first bit sits at the top
        tx_load   = ctrl_q.lsb ? dat_i : (dat_i << (5'd16 - len_new));

        status           = '0;
        status[STAT_BUSY] = (state_q != ST_IDLE);
        status[STAT_DONE] = done_q;
        status[STAT_OVR]  = ovr_q;

        if (rd) begin
            case (adr_i)
                OFFSET_SPI_CTRL:   dat_d = DW'(ctrl_q);
                OFFSET_SPI_DATA:   begin dat_d = rx_q;   done_d = 1'b0; end
                OFFSET_SPI_STATUS: begin dat_d = status; ovr_d  = 1'b0; end
                default:           dat_d = '0;
            endcase
        end

        if (wr && adr_i == OFFSET_SPI_CTRL) begin
            ctrl_d      = ctrl_t'(dat_i);
            ctrl_d.rsvd = 2'b00;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr && adr_i == OFFSET_SPI_DATA) begin
                    state_d     = ST_SETUP;
                    done_d      = 1'b0;
                    sh_d.lsb    = ctrl_q.lsb;
                    sh_d.ass    = ctrl_q.ass;
                    sh_d.tx_neg = ctrl_q.tx_neg;
                    sh_d.rx_neg = ctrl_q.rx_neg;
                    sh_d.div    = ctrl_q.div;
                    sh_d.len    = ctrl_q.len;
                    tx_d        = tx_load;
                    rxs_d       = '0;
                    edge_d      = 6'd0;
                    mosi_d      = ctrl_q.lsb ? tx_load[0] : tx_load[DW-1];
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tx_edge && !last_edge) begin
                    tx_d   = sh_q.lsb ? (tx_q >> 1) : (tx_q << 1);
                    mosi_d = sh_q.lsb ? tx_d[0] : tx_d[DW-1];
                end
                if (rx_edge) rxs_d = sh_q.lsb ? {miso_i, rxs_q[DW-1:1]} : {rxs_q[DW-2:0], miso_i};
                if (tick) begin
                    edge_d = edge_q + 6'd1;
                    if (last_edge) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d  = ST_IDLE;
                    rx_d     = sh_q.lsb ? (rxs_q >> (5'd16 - len_cur)) : rxs_q;
                    done_d   = 1'b1;
                    done_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr && adr_i == OFFSET_SPI_DATA && state_q != ST_IDLE) ovr_d = 1'b1;

        // A read clearing DONE takes effect on irq one cycle after its ack; a set is seen immediately
        irq_d = (done_q | done_set) & ctrl_q.ie;

        if (state_d != ST_IDLE) ss_n_d = sh_d.ass ? 1'b0 : ~ctrl_d.ss;
        else                    ss_n_d = ctrl_d.ass ? 1'b1 : ~ctrl_d.ss;
    end

    always_ff @(posedge clk64_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ctrl_q  <= ctrl_t'(CTRL_RST);
            sh_q    <= '0;
            tx_q    <= '0;
            rxs_q   <= '0;
            rx_q    <= '0;
            dat_q   <= '0;
            edge_q  <= 6'd0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            rxs_q   <= rxs_d;
            rx_q    <= rx_d;
            dat_q   <= dat_d;
            edge_q  <= edge_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            ack_q   <= ack_d;
            irq_q   <= irq_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
        end
    end

    assign dat_o  = dat_q;
    assign ack_o  = ack_q;
    assign irq_o  = irq_q;
    assign mosi_o = mosi_q;
    assign ss_n_o = ss_n_q;

endmodule
